// File: rtl/rnd_rb_arb_pkg.sv
// Shared switch-arbiter definitions: FSM state encoding and default sizing.
// Imported by rnd_rb_ppe and rnd_rb_arb.
package rnd_rb_arb_pkg;

    localparam int unsigned RR_WIDTH_DEF    = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rnd_rb_ppe.sv
// Combinational programmable priority encoder: picks the first set request bit
// at or after rr_priority, wrapping modulo RR_WIDTH (RR_WIDTH a power of 2).
module rnd_rb_ppe
    import rnd_rb_arb_pkg::*;
#(
    parameter int unsigned RR_WIDTH    = RR_WIDTH_DEF,
    parameter int unsigned RR_WIDTH_L2 = $clog2(RR_WIDTH)
) (
    input  logic [RR_WIDTH-1:0]    rr_vec_in,
    input  logic [RR_WIDTH_L2-1:0] rr_priority,
    output logic [RR_WIDTH-1:0]    rr_vec_out,
    output logic [RR_WIDTH_L2-1:0] rr_bin_out
);

    logic [RR_WIDTH_L2-1:0] w_idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        rr_vec_out = '0;
        rr_bin_out = '0;
        w_idx      = '0;
        for (int i = RR_WIDTH - 1; i >= 0; i--) begin
            w_idx = rr_priority + RR_WIDTH_L2'(i);
            if (rr_vec_in[w_idx]) begin
                rr_bin_out        = w_idx;
                rr_vec_out        = '0;
                rr_vec_out[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rnd_rb_arb.sv
// Sequential round-robin arbiter: holds the encoder's winner until release, then
// advances the pointer past it. Optional hold timeout via RND_RB_ARB_TIMEOUT_EN.
module rnd_rb_arb
    import rnd_rb_arb_pkg::*;
#(
    parameter int unsigned RR_WIDTH    = RR_WIDTH_DEF,
    parameter int unsigned RR_WIDTH_L2 = $clog2(RR_WIDTH),
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned TIMEOUT_W   = $clog2(TIMEOUT_CYC)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [RR_WIDTH-1:0]    i_req,
    input  logic [RR_WIDTH-1:0]    i_done,
    output logic [RR_WIDTH-1:0]    o_gnt_vec,
    output logic [RR_WIDTH_L2-1:0] o_gnt_bin,
    output logic                   o_gnt_vld,
    output logic [RR_WIDTH_L2-1:0] o_rr_ptr,
    output logic                   o_gnt_timeout
);

    if ((1 << RR_WIDTH_L2) != RR_WIDTH) begin : g_bad_width
        $error("rnd_rb_arb: RR_WIDTH must be a power of 2");
    end

    arb_state_e             r_state;
    arb_state_e             w_state_d;
    logic [RR_WIDTH-1:0]    r_gnt_vec;
    logic [RR_WIDTH-1:0]    w_gnt_vec_d;
    logic [RR_WIDTH_L2-1:0] r_gnt_bin;
    logic [RR_WIDTH_L2-1:0] w_gnt_bin_d;
    logic                   r_gnt_vld;
    logic                   w_gnt_vld_d;
    logic [RR_WIDTH_L2-1:0] r_ptr;
    logic [RR_WIDTH_L2-1:0] w_ptr_d;

    logic [RR_WIDTH-1:0]    w_ppe_vec;
    logic [RR_WIDTH_L2-1:0] w_ppe_bin;
    logic                   w_req_any;
    logic                   w_release;
    logic                   w_force;
    logic                   w_rel_all;

    rnd_rb_ppe #(
        .RR_WIDTH    (RR_WIDTH),
        .RR_WIDTH_L2 (RR_WIDTH_L2)
    ) u_ppe (
        .rr_vec_in   (i_req),
        .rr_priority (r_ptr),
        .rr_vec_out  (w_ppe_vec),
        .rr_bin_out  (w_ppe_bin)
    );

    assign w_req_any = |i_req;
    // Withdrawing the request counts as a release, same as done.
    assign w_release = i_done[r_gnt_bin] | ~i_req[r_gnt_bin];
    assign w_rel_all = w_release | w_force;

`ifdef RND_RB_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_hold_cnt;
    logic                 r_gnt_timeout;

    // A genuine release in the same cycle takes precedence over the timeout.
    assign w_force = (r_state == ARB_HOLD) && !w_release &&
                     (r_hold_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_hold_cnt    <= '0;
            r_gnt_timeout <= 1'b0;
        end else begin
            r_gnt_timeout <= w_force;
            if (r_state == ARB_IDLE) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + TIMEOUT_W'(1);
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_force      = 1'b0;
    assign w_unused_cfg = ^(TIMEOUT_W'(TIMEOUT_CYC - 1));
`endif

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ARB_IDLE: if (w_req_any) w_state_d = ARB_HOLD;
            ARB_HOLD: if (w_rel_all) w_state_d = ARB_IDLE;
            default:  w_state_d = ARB_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_gnt_vec = r_gnt_vec;
        o_gnt_bin = r_gnt_bin;
        o_gnt_vld = r_gnt_vld;
        o_rr_ptr  = r_ptr;
`ifdef RND_RB_ARB_TIMEOUT_EN
        o_gnt_timeout = r_gnt_timeout;
`else
        o_gnt_timeout = 1'b0;
`endif
    end

    // Grant and pointer next state; gnt_bin keeps its last value after release.
    always_comb begin
        w_gnt_vec_d = r_gnt_vec;
        w_gnt_bin_d = r_gnt_bin;
        w_gnt_vld_d = r_gnt_vld;
        w_ptr_d     = r_ptr;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_req_any) begin
                    w_gnt_vec_d = w_ppe_vec;
                    w_gnt_bin_d = w_ppe_bin;
                    w_gnt_vld_d = 1'b1;
                end
            end
            ARB_HOLD: begin
                if (w_rel_all) begin
                    w_gnt_vec_d = '0;
                    w_gnt_vld_d = 1'b0;
                    w_ptr_d     = r_gnt_bin + RR_WIDTH_L2'(1);
                end
            end
            default: begin
                w_gnt_vec_d = '0;
                w_gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_gnt_vec <= '0;
            r_gnt_bin <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_gnt_vec <= w_gnt_vec_d;
            r_gnt_bin <= w_gnt_bin_d;
            r_gnt_vld <= w_gnt_vld_d;
            r_ptr     <= w_ptr_d;
        end
    end

endmodule
